// File: rtl/imm_gen_pipe.sv
//-----------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined RV32I/RV64I immediate generator. Decodes the immediate of every
//   base instruction format from the opcode, sign-extends it to XLEN, flags
//   unknown opcodes and buffers {imm, fmt, illegal} in a DEPTH-entry FIFO with
//   valid/ready handshakes on both sides. Sits between fetch and the execute
//   operand mux.
//
// Parameters
//   XLEN   immediate width, 32 or 64
//   DEPTH  FIFO entries, power of two in 2..16
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     instruction word valid
//   in_ready     block can accept an instruction this cycle
//   instruction  raw 32-bit instruction word
//   out_valid    FIFO head valid
//   out_ready    consumer accepts the head this cycle
//   imm          sign-extended immediate at the head
//   fmt          head format: 0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   illegal      head opcode not recognised
//   count        FIFO occupancy
//
// Optional feature (macro IMM_STATS_EN)
//   illegal_cnt  16-bit saturating count of pushed illegal instructions
//   push_cnt     32-bit wrapping count of pushes
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module imm_gen_pipe #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              instruction,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          imm,
   output logic [2:0]               fmt,
   output logic                     illegal,
   output logic [$clog2(DEPTH):0]   count
`ifdef IMM_STATS_EN
   ,
   output logic [15:0]              illegal_cnt,
   output logic [31:0]              push_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } entry_t;

   // ---------------------------------------------------------------- decode
   fmt_e            w_fmt;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic            w_sign;

   assign w_sign = instruction[31];

   // NOTE: every output of a combinational block gets a default first so that
   // no path through the case leaves it unassigned, which would infer a latch.
   always_comb begin
      w_fmt   = FMT_ILL;
      w_imm32 = '0;
      case (instruction[6:0])
         7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
            w_fmt   = FMT_I;
            w_imm32 = {{20{w_sign}}, instruction[31:20]};
         end
         7'b0100011: begin
            w_fmt   = FMT_S;
            w_imm32 = {{20{w_sign}}, instruction[31:25], instruction[11:7]};
         end
         7'b1100011: begin
            w_fmt   = FMT_B;
            w_imm32 = {{20{w_sign}}, instruction[7], instruction[30:25],
                       instruction[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            w_fmt   = FMT_U;
            w_imm32 = {instruction[31:12], 12'b0};
         end
         7'b1101111: begin
            w_fmt   = FMT_J;
            w_imm32 = {{12{w_sign}}, instruction[19:12], instruction[20],
                       instruction[30:21], 1'b0};
         end
         7'b0110011, 7'b0111011: begin
            w_fmt   = FMT_R;
            w_imm32 = '0;
         end
         default: begin
            w_fmt   = FMT_ILL;
            w_imm32 = '0;
         end
      endcase
   end

   // The 32-bit immediate is already sign-correct; widen by replicating bit 31
   // (this is what makes U-type negative on RV64 when inst[31] is set).
   generate
      if (XLEN > 32) begin : g_sext
         assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
      end else begin : g_nosext
         assign w_imm = w_imm32[XLEN-1:0];
      end
   endgenerate

   entry_t w_entry;
   assign w_entry.imm     = w_imm;
   assign w_entry.fmt     = w_fmt;
   assign w_entry.illegal = (w_fmt == FMT_ILL);

   // ------------------------------------------------------------------ fifo
   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   entry_t          r_hold;
   entry_t          w_head;
   logic            w_push;
   logic            w_pop;

   // in_ready depends on registered occupancy only, so a full FIFO refuses a
   // push even in a cycle where the head is popped.
   assign in_ready  = (r_count != FULL);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign w_head    = r_mem[r_rd_ptr];

   // NOTE: the storage array has no reset; the occupancy counter alone
   // decides which entries are meaningful, so clearing it discards them.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   // NOTE: state registers use non-blocking assignments so that every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_hold   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_hold   <= w_head;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // When empty the outputs keep showing the last entry popped (zero after
   // reset) rather than whatever stale word sits under the read pointer.
   assign imm     = out_valid ? w_head.imm     : r_hold.imm;
   assign fmt     = out_valid ? w_head.fmt     : r_hold.fmt;
   assign illegal = out_valid ? w_head.illegal : r_hold.illegal;
   assign count   = r_count;

`ifdef IMM_STATS_EN
   // ----------------------------------------------------------------- stats
   logic [15:0] r_illegal_cnt;
   logic [31:0] r_push_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_illegal_cnt <= '0;
         r_push_cnt    <= '0;
      end else if (w_push) begin
         r_push_cnt <= r_push_cnt + 32'd1;
         if (w_entry.illegal && (r_illegal_cnt != 16'hFFFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 16'd1;
         end
      end
   end

   assign illegal_cnt = r_illegal_cnt;
   assign push_cnt    = r_push_cnt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
//-----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Self-checking bench for imm_gen_pipe (XLEN=64, DEPTH=2). A queue-based
//   reference model decodes immediates with signed arithmetic shifts and
//   tracks FIFO contents; directed steps cover the documented scenarios and a
//   randomized phase exercises mixed push/pop traffic.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_imm_gen_pipe;

   localparam int XLEN  = 64;
   localparam int DEPTH = 2;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] imm;
   logic [2:0]  fmt;
   logic        illegal;
   logic [1:0]  count;
`ifdef IMM_STATS_EN
   logic [15:0] illegal_cnt;
   logic [31:0] push_cnt;
`endif

   imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .imm         (imm),
      .fmt         (fmt),
      .illegal     (illegal)
`ifdef IMM_STATS_EN
      ,
      .illegal_cnt (illegal_cnt),
      .push_cnt    (push_cnt)
`endif
      ,
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ reference
   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        il;
   } exp_t;

   exp_t q[$];
   int   m_ill_cnt;
   int   m_push_cnt;
   int   errors;
   int   checks;
   bit   last_push;

   // Immediates built from the sign-extended word with arithmetic shifts and
   // masks, rather than bit-field concatenation.
   function automatic exp_t ref_decode(input logic [31:0] ins);
      exp_t   e;
      longint s;
      logic [6:0] op;
      s  = longint'($signed(ins));
      op = ins[6:0];
      e.il  = 1'b0;
      e.imm = 64'd0;
      if (op inside {7'h03, 7'h13, 7'h1B, 7'h67, 7'h73}) begin
         e.fmt = 3'd1;
         e.imm = s >>> 20;
      end else if (op == 7'h23) begin
         e.fmt = 3'd2;
         e.imm = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      end else if (op == 7'h63) begin
         e.fmt = 3'd3;
         e.imm = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                 (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      end else if (op == 7'h37 || op == 7'h17) begin
         e.fmt = 3'd4;
         e.imm = s & 64'hFFFF_FFFF_FFFF_F000;
      end else if (op == 7'h6F) begin
         e.fmt = 3'd5;
         e.imm = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                 (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      end else if (op == 7'h33 || op == 7'h3B) begin
         e.fmt = 3'd0;
      end else begin
         e.fmt = 3'd7;
         e.il  = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("count", 64'(count), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("head_imm", imm, q[0].imm);
         chk("head_fmt", 64'(fmt), 64'(q[0].fmt));
         chk("head_illegal", 64'(illegal), 64'(q[0].il));
      end
`ifdef IMM_STATS_EN
      chk("illegal_cnt", 64'(illegal_cnt), 64'(m_ill_cnt));
      chk("push_cnt", 64'(push_cnt), 64'(m_push_cnt));
`endif
   endtask

   // One clock with the inputs currently applied; model updated afterwards.
   task automatic step();
      bit   push;
      bit   pop;
      exp_t e;
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      e = ref_decode(instruction);
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      if (push) begin
         q.push_back(e);
         m_push_cnt++;
         if (e.il && m_ill_cnt < 16'hFFFF) m_ill_cnt++;
      end
      last_push = push;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [14];
      logic [31:0] r;
      ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
              7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00};
      r = $urandom();
      if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 13)];
      return r;
   endfunction

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
   endtask

   // -------------------------------------------------------------- stimulus
   initial begin
      errors      = 0;
      checks      = 0;
      m_ill_cnt   = 0;
      m_push_cnt  = 0;
      last_push   = 1'b0;
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      instruction = 32'd0;

      // Reset state
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_imm", imm, 64'd0);
      chk("rst_fmt", 64'(fmt), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check_outputs();

      // addi x1,x0,-1
      in_valid    = 1'b1;
      instruction = 32'hFFF0_0093;
      step();
      chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_fmt", 64'(fmt), 64'd1);
      chk("addi_count", 64'(count), 64'd1);

      // sw then beq with the consumer ready: each becomes the head in turn
      out_ready   = 1'b1;
      instruction = 32'h0011_2423;
      step();
      chk("sw_imm", imm, 64'h8);
      chk("sw_fmt", 64'(fmt), 64'd2);
      instruction = 32'hFE00_0EE3;
      step();
      chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("beq_fmt", 64'(fmt), 64'd3);
      instruction = 32'h1234_50B7;
      step();
      chk("lui_imm", imm, 64'h0000_0000_1234_5000);
      chk("lui_fmt", 64'(fmt), 64'd4);
      instruction = 32'h0000_007F;
      step();
      chk("ill_imm", imm, 64'd0);
      chk("ill_fmt", 64'(fmt), 64'd7);
      chk("ill_flag", 64'(illegal), 64'd1);
`ifdef IMM_STATS_EN
      chk("ill_cnt_one", 64'(illegal_cnt), 64'd1);
`endif
      drain();

      // Fill with the consumer stalled, try a third push, hold, then pop once
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      instruction = 32'h8000_006F;
      step();
      instruction = 32'h8000_0037;
      step();
      chk("full_count", 64'(count), 64'd2);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      instruction = 32'h0010_0013;
      step();
      chk("full_ignored_count", 64'(count), 64'd2);
      in_valid = 1'b0;
      repeat (5) begin
         step();
         chk("hold_imm", imm, 64'hFFFF_FFFF_FFF0_0000);
      end
      out_ready = 1'b1;
      step();
      chk("pop1_count", 64'(count), 64'd1);
      chk("pop1_in_ready", 64'(in_ready), 64'd1);
      drain();

      // Full throughput: occupancy stays at one, pointers wrap
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         instruction = rand_inst();
         step();
         chk("thru_count", 64'(count), 64'd1);
      end
      drain();

      // Asynchronous reset mid-cycle with two entries stored
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      instruction = 32'h0040_0093;
      step();
      instruction = 32'h0000_0033;
      step();
      in_valid = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      q.delete();
      m_ill_cnt  = 0;
      m_push_cnt = 0;
      chk("async_out_valid", 64'(out_valid), 64'd0);
      chk("async_count", 64'(count), 64'd0);
      chk("async_imm", imm, 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("release_in_ready", 64'(in_ready), 64'd1);
      check_outputs();

      // Randomized traffic; instruction held until accepted
      for (int i = 0; i < 300; i++) begin
         if (!in_valid || last_push) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            instruction = rand_inst();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the RV64I/RV32I datapath; successor to the single-cycle combinational immediate extractor.
- Decodes all base formats (R/I/S/B/U/J), sign-extends to XLEN, flags illegal opcodes, and buffers results in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between instruction fetch and the execute-stage operand mux.

Parameters:
- XLEN, 64, immediate output width; legal values 32 or 64.
- DEPTH, 2, output FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  clock; all state on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction word valid.
- in_ready  output  1  block can accept an instruction this cycle.
- instruction  input  32  raw instruction word.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head this cycle.
- imm  output  XLEN  sign-extended immediate at the FIFO head.
- fmt  output  3  format at the head: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- illegal  output  1  head opcode is not recognised.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, out_valid=0, imm=0, fmt=0, illegal=0, in_ready=1. Stored entries are discarded on reset, including mid-operation.
- Decode is combinational on instruction[6:0]:
  - I: 0000011, 0010011, 0011011, 1100111, 1110011 → imm = sext(inst[31:20]).
  - S: 0100011 → imm = sext({inst[31:25], inst[11:7]}).
  - B: 1100011 → imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: 0110111, 0010111 → imm = sext({inst[31:12], 12'b0}).
  - J: 1101111 → imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R: 0110011, 0111011 → imm = 0, fmt = 0.
  - Any other opcode → imm = 0, fmt = 7, illegal = 1.
- Sign extension replicates inst[31] up to XLEN-1. U-type with XLEN=64 extends bit 31.
- Push: in_valid & in_ready writes {imm, fmt, illegal} at the write pointer.
- Pop: out_valid & out_ready advances the read pointer.
- in_ready = (count < DEPTH), registered-state based. There is no combinational path from out_ready to in_ready, so a full FIFO does not accept even when a pop occurs in the same cycle.
- Latency: an entry pushed in cycle N is visible on out_valid/imm in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop (count ≥ 1 and not full): count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count goes +1 on push only, -1 on pop only.
- Outputs imm/fmt/illegal show the FIFO head whenever out_valid=1. When empty they hold their last value and consumers must ignore them.
- Holding rule: while out_valid=1 and out_ready=0, imm/fmt/illegal remain stable.
- in_valid with in_ready=0 has no effect. The producer must hold instruction until accepted.

Optional Feature:
- IMM_STATS_EN defined: adds output ports illegal_cnt (16 bits) and push_cnt (32 bits).
  - illegal_cnt increments on each push with illegal=1 and saturates at 0xFFFF.
  - push_cnt increments on every push and wraps.
  - Both counters reset to 0 on reset_n low.
- IMM_STATS_EN undefined: these ports and counters do not exist, and the interface is exactly as listed above.

Test Plan:
- Reset then push 0xFFF00093 (addi x1,x0,-1) → next cycle out_valid=1, imm=0xFFFF_FFFF_FFFF_FFFF, fmt=1, illegal=0, count=1.
- Push 0x00112423 (sw x1,8(x2)), then 0xFE000EE3 (beq -4), with out_ready=1 → in order: imm=0x8 with fmt=2, then imm=0xFFFF_FFFF_FFFF_FFFC with fmt=3.
- Push 0x123450B7 (lui) → imm=0x0000_0000_1234_5000, fmt=4. Push 0x0000007F → imm=0, fmt=7, illegal=1 (illegal_cnt=1 with IMM_STATS_EN).
- out_ready=0, push DEPTH=2 words back-to-back → count=2, in_ready=0. A third in_valid is ignored. Hold 5 cycles → head stable. Raise out_ready for one cycle → count=1, in_ready=1 next cycle.
- Continuous push and pop at full throughput over 10 instructions → count stays 1, pointers wrap, output order equals input order.
- With 2 entries stored, assert reset_n=0 asynchronously mid-cycle → out_valid=0 and count=0 immediately, in_ready=1 after release.
